// File: rtl/spw_tcr_credit_pkg.sv
// SpaceWire flow-control credit manager: shared constants, state type
// and the widened grant check.
package spw_tcr_credit_pkg;

  localparam int MAX_CREDIT = 56;
  localparam int FCT_CREDIT = 8;
  localparam int CREDIT_W   = 6;
  localparam int FIFO_CNT_W = 7;

  typedef enum logic [1:0] {
    DISABLED,
    IDLE,
    FCT_PENDING,
    ERROR
  } state_e;

  // One more FCT is allowed if it stays within the credit limit and
  // the Rx FIFO can absorb everything we would then have promised.
  function automatic logic grant_ok(
    input logic [CREDIT_W-1:0]   rx_credit,
    input logic [FIFO_CNT_W-1:0] fifo_free
  );
    logic [CREDIT_W:0] need;
    need = {1'b0, rx_credit} + (CREDIT_W+1)'(FCT_CREDIT);
    return (need <= (CREDIT_W+1)'(MAX_CREDIT)) &&
           (fifo_free >= FIFO_CNT_W'(need));
  endfunction

endpackage

// File: rtl/spw_tcr_credit_counter.sv
// One direction of credit: +FCT_CREDIT on inc8, -1 on dec1, with
// overflow/underflow flags describing the update requested this cycle.
module spw_tcr_credit_counter
  import spw_tcr_credit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                hold,
  input  logic                inc8,
  input  logic                dec1,
  output logic [CREDIT_W-1:0] count,
  output logic                overflow,
  output logic                underflow
);

  logic [CREDIT_W-1:0] count_q;
  logic [CREDIT_W-1:0] count_d;
  logic [CREDIT_W:0]   sum;

  always_comb begin
    sum = {1'b0, count_q};
    if (inc8) sum = sum + (CREDIT_W+1)'(FCT_CREDIT);
    if (dec1) sum = sum - (CREDIT_W+1)'(1);
    underflow = dec1 && !inc8 && (count_q == '0);
    overflow  = !underflow && (sum > (CREDIT_W+1)'(MAX_CREDIT));
    count_d   = count_q;
    if (clr)
      count_d = '0;
    else if (!hold && !underflow)
      count_d = sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/spw_tcr_credit_ctrl.sv
// Tx/Rx credit tracking, FCT request handshake and creditError
// generation for the SpaceWire link FSM.
module spw_tcr_credit_ctrl
  import spw_tcr_credit_pkg::*;
(
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  enable,
  input  logic                  gotFCT,
  input  logic                  gotNChar,
  input  logic                  ncharSent,
  input  logic                  fctSent,
  input  logic [FIFO_CNT_W-1:0] rxFifoFree,
  output logic [CREDIT_W-1:0]   txCredit,
  output logic                  txCreditAvail,
  output logic [CREDIT_W-1:0]   rxCredit,
  output logic                  fctRequest,
  output logic                  creditError
);

  state_e state_q;
  state_e state_d;
  logic   active;
  logic   pending;
  logic   clr;
  logic   err_now;
  logic   tx_ovf;
  logic   tx_udf;
  logic   rx_ovf;
  logic   rx_udf;

  assign active  = (state_q == IDLE) || (state_q == FCT_PENDING);
  assign pending = (state_q == FCT_PENDING);
  assign clr     = !enable || (state_q == DISABLED);
  assign err_now = active && (tx_ovf || rx_ovf || rx_udf);

  // The offending event is not applied: both counters freeze on error.
  spw_tcr_credit_counter u_tx (
    .clk       (CLOCK),
    .rst       (RESET),
    .clr       (clr),
    .hold      (err_now),
    .inc8      (active && gotFCT),
    .dec1      (active && ncharSent),
    .count     (txCredit),
    .overflow  (tx_ovf),
    .underflow (tx_udf)
  );

  spw_tcr_credit_counter u_rx (
    .clk       (CLOCK),
    .rst       (RESET),
    .clr       (clr),
    .hold      (err_now),
    .inc8      (pending && fctSent),
    .dec1      (active && gotNChar),
    .count     (rxCredit),
    .overflow  (rx_ovf),
    .underflow (rx_udf)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISABLED:    state_d = IDLE;
      IDLE: begin
        if (err_now)
          state_d = ERROR;
        else if (grant_ok(rxCredit, rxFifoFree))
          state_d = FCT_PENDING;
      end
      FCT_PENDING: begin
        if (err_now)      state_d = ERROR;
        else if (fctSent) state_d = IDLE;
      end
      ERROR:       state_d = ERROR;
      default:     state_d = DISABLED;
    endcase
    if (!enable) state_d = DISABLED;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= DISABLED;
    else       state_q <= state_d;
  end

  assign txCreditAvail = (txCredit != '0);
  assign fctRequest    = pending;
  assign creditError   = (state_q == ERROR);

  a_tx_no_credit: assert property (
    @(posedge CLOCK) disable iff (RESET) !tx_udf);
  a_fct_sent_legal: assert property (
    @(posedge CLOCK) disable iff (RESET) fctSent |-> pending);

endmodule

// File: tb/tb_spw_tcr_credit_ctrl.sv
// Randomized + directed bench for spw_tcr_credit_ctrl with a
// queue-based scoreboard fed by a credit-rule reference model.
module tb_spw_tcr_credit_ctrl;
  import spw_tcr_credit_pkg::*;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       enable = 1'b0;
  logic       gotFCT = 1'b0;
  logic       gotNChar = 1'b0;
  logic       ncharSent = 1'b0;
  logic       fctSent = 1'b0;
  logic [6:0] rxFifoFree = '0;
  logic [5:0] txCredit;
  logic [5:0] rxCredit;
  logic       txCreditAvail;
  logic       fctRequest;
  logic       creditError;

  spw_tcr_credit_ctrl dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .enable        (enable),
    .gotFCT        (gotFCT),
    .gotNChar      (gotNChar),
    .ncharSent     (ncharSent),
    .fctSent       (fctSent),
    .rxFifoFree    (rxFifoFree),
    .txCredit      (txCredit),
    .txCreditAvail (txCreditAvail),
    .rxCredit      (rxCredit),
    .fctRequest    (fctRequest),
    .creditError   (creditError)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [5:0] tx;
    logic       av;
    logic [5:0] rx;
    logic       req;
    logic       err;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  int m_tx = 0;
  int m_rx = 0;
  bit m_on = 0;
  bit m_pend = 0;
  bit m_err = 0;

  task automatic step(input bit rst, input bit en, input bit gf,
                      input bit gn, input bit ns, input bit fs,
                      input int free);
    int ntx;
    int nrx;
    bit grant;
    @(negedge CLOCK);
    fs = fs && m_pend && !rst;
    ns = ns && (m_tx > 0);
    RESET = rst;
    enable = en;
    gotFCT = gf;
    gotNChar = gn;
    ncharSent = ns;
    fctSent = fs;
    rxFifoFree = 7'(free);
    if (rst || !en) begin
      m_on = 0; m_pend = 0; m_err = 0; m_tx = 0; m_rx = 0;
    end else if (!m_on) begin
      m_on = 1;
    end else if (!m_err) begin
      ntx = m_tx + (gf ? 8 : 0) - (ns ? 1 : 0);
      nrx = m_rx + (fs ? 8 : 0) - (gn ? 1 : 0);
      grant = (m_rx + 8 <= 56) && (free >= m_rx + 8);
      if (ntx > 56 || nrx < 0 || nrx > 56) begin
        m_err = 1;
        m_pend = 0;
      end else begin
        m_tx = ntx;
        m_rx = nrx;
        if (m_pend) m_pend = !fs;
        else        m_pend = grant;
      end
    end
    sb_q.push_back(exp_t'({6'(m_tx), m_tx != 0, 6'(m_rx),
                           m_pend, m_err}));
  endtask

  task automatic idle(input int n, input bit en, input int free);
    for (int i = 0; i < n; i++) step(0, en, 0, 0, 0, 0, free);
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL timeout: test did not finish in time (phase %s)",
             phase);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    forever begin
      @(posedge CLOCK);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        exp_t a;
        e = sb_q.pop_front();
        a = {txCredit, txCreditAvail, rxCredit, fctRequest, creditError};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got tx=%0d av=%0d rx=%0d req=%0d err=%0d want tx=%0d av=%0d rx=%0d req=%0d err=%0d",
                   phase, a.tx, a.av, a.rx, a.req, a.err,
                   e.tx, e.av, e.rx, e.req, e.err);
        end
      end
    end
  end

  initial begin
    bit gf, gn, ns, rst, en;
    int free;

    phase = "reset";
    repeat (3) step(1, 1, 0, 0, 0, 0, 64);
    @(negedge CLOCK);
    n_cmp++;
    if ({txCredit, txCreditAvail, rxCredit, fctRequest, creditError}
        !== '0) begin
      n_bad++;
      $display("FAIL reset: outputs not 0 tx=%0d av=%0d rx=%0d req=%0d err=%0d",
               txCredit, txCreditAvail, rxCredit, fctRequest,
               creditError);
    end
    phase = "handshake";
    for (int i = 0; i < 60; i++)
      step(0, 1, 0, 0, 0, 1'($urandom_range(0, 1)), 64);

    phase = "tx_overflow";
    step(1, 1, 0, 0, 0, 0, 0);
    idle(2, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0, 0);
    idle(3, 1, 0);

    phase = "rx_underflow";
    idle(1, 0, 8);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 1, 8);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 1, 0, 0, 8);
    idle(2, 1, 8);
    idle(2, 0, 8);

    phase = "tx_boundary";
    idle(2, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0);
    idle(2, 1, 0);

    phase = "fifo_limit";
    idle(1, 0, 10);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 1, 10);
    idle(4, 1, 10);
    idle(3, 1, 16);
    step(0, 1, 0, 0, 0, 1, 16);
    idle(3, 1, 16);

    phase = "disable_pending";
    idle(1, 0, 64);
    for (int i = 0; i < 5 && !m_pend; i++) idle(1, 1, 64);
    step(0, 0, 0, 0, 0, 1, 64);
    idle(3, 1, 64);

    phase = "random";
    free = 64;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 59) != 0);
      gf  = (m_tx <= 48) ? ($urandom_range(0, 99) < 15)
                         : ($urandom_range(0, 99) < 3);
      ns  = ($urandom_range(0, 99) < 40);
      gn  = (m_rx > 0) ? ($urandom_range(0, 99) < 40)
                       : ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 19) == 0) free = $urandom_range(0, 64);
      step(rst, en, gf, gn, ns, 1'($urandom_range(0, 1)), free);
    end

    phase = "drain";
    idle(2, 1, 64);
    @(posedge CLOCK);
    #2;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never compared",
               sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
